// File: rtl/alu_pkg.sv
// alu_pkg: shared width constant and operation encoding for alu_64.
// Imported by alu_addsub and alu_64.
package alu_pkg;

  localparam int ALU_W = 64;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } alu_op_e;

endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: shared 64-bit adder; sub=1 gives a + ~b + 1.
// Ports: a, b (operands), sub (subtract), sum (carry-out dropped).
module alu_addsub
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic             sub,
  output logic [ALU_W-1:0] sum
);

  logic [ALU_W-1:0] b_eff;
  logic [ALU_W-1:0] cin;

  always_comb begin
    b_eff = sub ? ~b : b;
    cin   = {{(ALU_W-1){1'b0}}, sub};
    // Sum is truncated to ALU_W bits, so the carry out of the MSB is lost.
    sum   = a + b_eff + cin;
  end

endmodule

// File: rtl/alu_64.sv
// alu_64: 1-cycle registered ADD/SUB/AND/XOR with signed overflow.
// Ports: clk, rst_n (sync, active low), in_valid, a, b, control,
//   out_valid, result, overflow; zero, sign when ALU_FLAGS_EN is defined.
module alu_64
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [1:0]       control,
  output logic             out_valid,
  output logic [ALU_W-1:0] result,
  output logic             overflow
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             sign
`endif
);

  localparam int MSB = ALU_W - 1;

  alu_op_e          op;
  logic             sub;
  logic [ALU_W-1:0] sum;
  logic [ALU_W-1:0] op_res;
  logic             op_ov;

  logic             out_valid_d, out_valid_q;
  logic [ALU_W-1:0] result_d, result_q;
  logic             overflow_d, overflow_q;

  assign op  = alu_op_e'(control);
  assign sub = (op == OP_SUB);

  alu_addsub u_addsub (
    .a   (a),
    .b   (b),
    .sub (sub),
    .sum (sum)
  );

  always_comb begin
    op_res = '0;
    op_ov  = 1'b0;
    unique case (op)
      OP_ADD: begin
        op_res = sum;
        op_ov  = (a[MSB] == b[MSB]) &&
                 (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        op_res = sum;
        op_ov  = (a[MSB] != b[MSB]) &&
                 (sum[MSB] != a[MSB]);
      end
      OP_AND: op_res = a & b;
      OP_XOR: op_res = a ^ b;
      default: op_res = '0;
    endcase
  end

  always_comb begin
    out_valid_d = in_valid;
    result_d    = result_q;
    overflow_d  = overflow_q;
    if (in_valid) begin
      result_d   = op_res;
      overflow_d = op_ov;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;

`ifdef ALU_FLAGS_EN
  logic zero_d, zero_q;
  logic sign_d, sign_q;

  always_comb begin
    zero_d = zero_q;
    sign_d = sign_q;
    if (in_valid) begin
      zero_d = (op_res == '0);
      sign_d = op_res[MSB];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      sign_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
      sign_q <= sign_d;
    end
  end

  assign zero = zero_q;
  assign sign = sign_q;
`endif

endmodule

// File: tb/tb_alu_64.sv
// tb_alu_64: directed self-checking bench for alu_64.
// Flag ports are checked when ALU_FLAGS_EN is defined.
module tb_alu_64;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] a;
  logic [63:0] b;
  logic [1:0]  control;
  logic        out_valid;
  logic [63:0] result;
  logic        overflow;
`ifdef ALU_FLAGS_EN
  logic        zero;
  logic        sign;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  alu_64 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .control   (control),
    .out_valid (out_valid),
    .result    (result),
    .overflow  (overflow)
`ifdef ALU_FLAGS_EN
    ,
    .zero      (zero),
    .sign      (sign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Drive one cycle at negedge, let the posedge take it, check at
  // the following negedge.
  task automatic step(input string       tag,
                      input logic        v,
                      input logic [1:0]  c,
                      input logic [63:0] x,
                      input logic [63:0] y,
                      input logic [63:0] er,
                      input logic        eo);
    in_valid = v;
    control  = c;
    a        = x;
    b        = y;
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".vld"}, {63'b0, out_valid}, {63'b0, v});
    chk({tag, ".res"}, result, er);
    chk({tag, ".ovf"}, {63'b0, overflow}, {63'b0, eo});
`ifdef ALU_FLAGS_EN
    begin
      logic ez;
      logic es;
      ez = (er == 64'd0);
      es = er[63];
      chk({tag, ".zero"}, {63'b0, zero}, {63'b0, ez});
      chk({tag, ".sign"}, {63'b0, sign}, {63'b0, es});
    end
`endif
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".vld"}, {63'b0, out_valid}, 64'd0);
    chk({tag, ".res"}, result, 64'd0);
    chk({tag, ".ovf"}, {63'b0, overflow}, 64'd0);
`ifdef ALU_FLAGS_EN
    chk({tag, ".zero"}, {63'b0, zero}, 64'd0);
    chk({tag, ".sign"}, {63'b0, sign}, 64'd0);
`endif
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    control  = 2'd0;
    a        = '0;
    b        = '0;
    @(negedge clk);
    @(negedge clk);
    chk_reset("rst0");
    rst_n = 1'b1;

    step("add_maxp", 1, 2'd0, MAXP, MAXP,
         64'hFFFF_FFFF_FFFF_FFFE, 1);
    step("add_minn", 1, 2'd0, MINN, MINN,
         64'd0, 1);
    step("add_ones", 1, 2'd0, ONES, MINN,
         MAXP, 1);
    step("sub_pn", 1, 2'd1, MAXP, MINN,
         ONES, 1);
    step("sub_np", 1, 2'd1, MINN, MAXP,
         64'd1, 1);
    step("and_5e", 1, 2'd2, 64'h5, 64'hE,
         64'h4, 0);
    step("xor_5e", 1, 2'd3, 64'h5, 64'hE,
         64'hB, 0);
    step("xor_top", 1, 2'd3, ONES, MINN,
         MAXP, 0);
    step("add_3_4", 1, 2'd0, 64'd3, 64'd4,
         64'd7, 0);
    step("sub_5_7", 1, 2'd1, 64'd5, 64'd7,
         64'hFFFF_FFFF_FFFF_FFFE, 0);

    // Idle cycles must hold the last result and flags.
    step("hold1", 0, 2'd0, MAXP, MAXP,
         64'hFFFF_FFFF_FFFF_FFFE, 0);
    step("hold2", 0, 2'd2, ONES, ONES,
         64'hFFFF_FFFF_FFFF_FFFE, 0);
    step("add_ov", 1, 2'd0, MAXP, 64'd1,
         MINN, 1);
    step("hold3", 0, 2'd3, 64'd0, 64'd0,
         MINN, 1);

    // Reset wins over an operation presented in the same cycle.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    control  = 2'd0;
    a        = 64'd3;
    b        = 64'd4;
    @(posedge clk);
    @(negedge clk);
    chk_reset("rst_op");
    rst_n = 1'b1;

    step("bb0", 1, 2'd0, 64'd10, 64'd20,
         64'd30, 0);
    step("bb1", 1, 2'd1, 64'd10, 64'd20,
         64'hFFFF_FFFF_FFFF_FFF6, 0);
    step("bb2", 1, 2'd2, 64'hF0F0, 64'hFF00,
         64'hF000, 0);
    step("bb3", 1, 2'd3, 64'hF0F0, 64'hFF00,
         64'h0FF0, 0);
    step("bb_end", 0, 2'd0, 64'd0, 64'd0,
         64'h0FF0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
